// File: rtl/maze_grid_responder.sv
// maze_grid_responder
//   Holds the maze wall map and answers wall-occupancy queries from two
//   ray-casting requesters (port A: horizontal-grid-line finder, port B:
//   vertical-grid-line finder). A query converts a world (x,y) coordinate to a
//   grid cell, bounds-checks it and returns wall/oob flags over a req/ack
//   handshake. Ack follows the sampling edge by two cycles. At most one query
//   completes every three cycles.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   load_en/row/data        write one map row per cycle (1 = wall, bit c = column c)
//   qa_req, qa_x, qa_y      port A level request and world coordinate
//   qa_ack, qa_wall, qa_oob port A one-cycle ack and held result flags
//   qb_*                    identical to port A, for port B
module maze_grid_responder #(
    parameter int unsigned GRID_W     = 16,
    parameter int unsigned GRID_H     = 16,
    parameter int unsigned CELL_SHIFT = 6,
    parameter int unsigned COORD_W    = 12
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load_en,
    input  logic [$clog2(GRID_H)-1:0] load_row,
    input  logic [GRID_W-1:0]         load_data,
    input  logic                      qa_req,
    input  logic [COORD_W-1:0]        qa_x,
    input  logic [COORD_W-1:0]        qa_y,
    output logic                      qa_ack,
    output logic                      qa_wall,
    output logic                      qa_oob,
    input  logic                      qb_req,
    input  logic [COORD_W-1:0]        qb_x,
    input  logic [COORD_W-1:0]        qb_y,
    output logic                      qb_ack,
    output logic                      qb_wall,
    output logic                      qb_oob
);

    localparam int unsigned RowW = $clog2(GRID_H);
    localparam int unsigned ColW = $clog2(GRID_W);

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StRespond
    } state_e;

    state_e               state_q;
    logic                 grant_b_q;       // port owning the in-flight query
    logic                 last_grant_b_q;  // port granted most recently
    logic [COORD_W-1:0]   x_q;
    logic [COORD_W-1:0]   y_q;
    logic                 res_wall_q;
    logic                 res_oob_q;
    logic [GRID_W-1:0]    map_q [GRID_H];

    logic                 pick_b;
    logic [COORD_W-1:0]   lk_col;
    logic [COORD_W-1:0]   lk_row;
    logic                 lk_oob;
    logic                 lk_wall;

    // On a tie the port that was not served last wins, so neither starves.
    always_comb begin
        pick_b = qb_req && (!qa_req || !last_grant_b_q);
    end

    // Full-width shifts keep wrapped-negative coordinates large, hence oob.
    always_comb begin
        lk_col  = x_q >> CELL_SHIFT;
        lk_row  = y_q >> CELL_SHIFT;
        lk_oob  = (lk_col >= COORD_W'(GRID_W)) || (lk_row >= COORD_W'(GRID_H));
        lk_wall = 1'b0;
        if (!lk_oob) begin
            lk_wall = map_q[lk_row[RowW-1:0]][lk_col[ColW-1:0]];
        end
    end

    // Map storage runs independently of the FSM; a lookup registering on the
    // same edge as a write still reads the old row.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(GRID_H); i++) begin
                map_q[i] <= '0;
            end
        end else if (load_en) begin
            map_q[load_row] <= load_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            grant_b_q      <= 1'b0;
            last_grant_b_q <= 1'b1;
            x_q            <= '0;
            y_q            <= '0;
            res_wall_q     <= 1'b0;
            res_oob_q      <= 1'b0;
            qa_ack         <= 1'b0;
            qa_wall        <= 1'b0;
            qa_oob         <= 1'b0;
            qb_ack         <= 1'b0;
            qb_wall        <= 1'b0;
            qb_oob         <= 1'b0;
        end else begin
            qa_ack <= 1'b0;
            qb_ack <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (qa_req || qb_req) begin
                        grant_b_q      <= pick_b;
                        last_grant_b_q <= pick_b;
                        x_q            <= pick_b ? qb_x : qa_x;
                        y_q            <= pick_b ? qb_y : qa_y;
                        state_q        <= StLookup;
                    end
                end
                StLookup: begin
                    res_wall_q <= lk_wall;
                    res_oob_q  <= lk_oob;
                    state_q    <= StRespond;
                end
                StRespond: begin
                    // Only the granted port's result registers move.
                    if (grant_b_q) begin
                        qb_ack  <= 1'b1;
                        qb_wall <= res_wall_q;
                        qb_oob  <= res_oob_q;
                    end else begin
                        qa_ack  <= 1'b1;
                        qa_wall <= res_wall_q;
                        qa_oob  <= res_oob_q;
                    end
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maze_grid_responder.sv
// Scoreboard bench for maze_grid_responder: drivers push expected results from
// a cell-level model into per-port queues; a monitor pops them on every ack.
module tb_maze_grid_responder;

    localparam int GW   = 16;
    localparam int GH   = 16;
    localparam int CELL = 64;

    typedef struct packed {
        logic wall;
        logic oob;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  load_row = '0;
    logic [15:0] load_data = '0;
    logic        qa_req = 1'b0;
    logic [11:0] qa_x = '0;
    logic [11:0] qa_y = '0;
    logic        qa_ack, qa_wall, qa_oob;
    logic        qb_req = 1'b0;
    logic [11:0] qb_x = '0;
    logic [11:0] qb_y = '0;
    logic        qb_ack, qb_wall, qb_oob;

    maze_grid_responder dut (
        .clock     (clock),
        .reset     (reset),
        .load_en   (load_en),
        .load_row  (load_row),
        .load_data (load_data),
        .qa_req    (qa_req),
        .qa_x      (qa_x),
        .qa_y      (qa_y),
        .qa_ack    (qa_ack),
        .qa_wall   (qa_wall),
        .qa_oob    (qa_oob),
        .qb_req    (qb_req),
        .qb_x      (qb_x),
        .qb_y      (qb_y),
        .qb_ack    (qb_ack),
        .qb_wall   (qb_wall),
        .qb_oob    (qb_oob)
    );

    always #5 clock = ~clock;

    exp_t        qa_exp[$];
    exp_t        qb_exp[$];
    logic [1:0]  held_a = '0;
    logic [1:0]  held_b = '0;
    logic [15:0] mdl_map [GH];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Cell-level reference: world units -> cell by integer division.
    function automatic exp_t model(input logic [11:0] x, input logic [11:0] y);
        exp_t e;
        int col = int'(x) / CELL;
        int row = int'(y) / CELL;
        e.oob  = (col >= GW) || (row >= GH);
        e.wall = e.oob ? 1'b0 : mdl_map[row][col];
        return e;
    endfunction

    // Monitor: pops on ack, otherwise results must hold their last acked value.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                qa_exp.delete();
                qb_exp.delete();
                held_a = '0;
                held_b = '0;
                check("reset_outputs", {26'd0, qa_ack, qa_wall, qa_oob, qb_ack, qb_wall, qb_oob},
                      32'd0);
            end else begin
                if (qa_ack) begin
                    if (qa_exp.size() == 0) begin
                        check("a_spurious_ack", {31'd0, qa_ack}, 32'd0);
                    end else begin
                        e = qa_exp.pop_front();
                        check("a_wall", {31'd0, qa_wall}, {31'd0, e.wall});
                        check("a_oob", {31'd0, qa_oob}, {31'd0, e.oob});
                        held_a = e;
                    end
                end else begin
                    check("a_hold", {30'd0, qa_wall, qa_oob}, {30'd0, held_a});
                end
                if (qb_ack) begin
                    if (qb_exp.size() == 0) begin
                        check("b_spurious_ack", {31'd0, qb_ack}, 32'd0);
                    end else begin
                        e = qb_exp.pop_front();
                        check("b_wall", {31'd0, qb_wall}, {31'd0, e.wall});
                        check("b_oob", {31'd0, qb_oob}, {31'd0, e.oob});
                        held_b = e;
                    end
                end else begin
                    check("b_hold", {30'd0, qb_wall, qb_oob}, {30'd0, held_b});
                end
            end
        end
    end

    // One query on one port; latency counts rising edges from the sampling
    // edge (1) through the edge that raises ack. exp_lat <= 0 skips that check.
    task automatic do_query(input bit pb, input logic [11:0] x, input logic [11:0] y,
                            input int exp_lat, input bit scramble);
        int n = 0;
        bit got = 1'b0;
        @(negedge clock);
        if (pb) begin
            qb_req = 1'b1; qb_x = x; qb_y = y; qb_exp.push_back(model(x, y));
        end else begin
            qa_req = 1'b1; qa_x = x; qa_y = y; qa_exp.push_back(model(x, y));
        end
        while (!got && n < 30) begin
            @(posedge clock);
            #1;
            n++;
            got = pb ? qb_ack : qa_ack;
            // Coordinates are registered at the grant edge; garbage afterwards.
            if (scramble && n == 1) begin
                if (pb) begin qb_x = 12'($urandom); qb_y = 12'($urandom); end
                else begin qa_x = 12'($urandom); qa_y = 12'($urandom); end
            end
        end
        if (pb) qb_req = 1'b0;
        else qa_req = 1'b0;
        if (!got) check(pb ? "b_ack_timeout" : "a_ack_timeout", {31'd0, got}, 32'd1);
        else if (exp_lat > 0) check(pb ? "b_latency" : "a_latency", n, exp_lat);
    endtask

    task automatic load(input int r, input logic [15:0] d);
        @(negedge clock);
        load_en = 1'b1; load_row = 4'(r); load_data = d;
        @(posedge clock);
        mdl_map[r] = d;
        #1 load_en = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #2 reset = 1'b1;
        for (int i = 0; i < GH; i++) mdl_map[i] = '0;
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < GH; i++) mdl_map[i] = '0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;

        // Basic wall hit on A, miss on B; A must keep its result.
        load(2, 16'h0010);
        do_query(1'b0, 12'd300, 12'd130, 3, 1'b1);
        do_query(1'b1, 12'd320, 12'd191, 3, 1'b1);

        // Out-of-bounds in x and y (y=4095 models a wrapped negative).
        do_query(1'b0, 12'd1024, 12'd10, 3, 1'b0);
        do_query(1'b0, 12'd5, 12'd4095, 3, 1'b0);

        // Simultaneous requests after reset: A first, B three cycles later.
        pulse_reset();
        load(2, 16'h0010);
        fork
            do_query(1'b0, 12'd300, 12'd130, 3, 1'b0);
            do_query(1'b1, 12'd320, 12'd130, 6, 1'b0);
        join
        // B was served last, so make A the last grant before the next tie.
        do_query(1'b0, 12'd0, 12'd0, 3, 1'b0);
        fork
            do_query(1'b0, 12'd300, 12'd130, 6, 1'b0);
            do_query(1'b1, 12'd256, 12'd128, 3, 1'b0);
        join

        // Row write on the lookup edge: that query sees the old wall.
        fork
            do_query(1'b0, 12'd300, 12'd130, 3, 1'b0);
            begin
                @(negedge clock);
                @(posedge clock);
                @(negedge clock);
                load_en = 1'b1; load_row = 4'd2; load_data = 16'h0000;
                @(posedge clock);
                mdl_map[2] = 16'h0000;
                #1 load_en = 1'b0;
            end
        join
        do_query(1'b0, 12'd300, 12'd130, 3, 1'b0);

        // Reset while in LOOKUP: query dropped, map cleared.
        load(2, 16'h0010);
        @(negedge clock);
        qa_req = 1'b1; qa_x = 12'd300; qa_y = 12'd130;
        @(posedge clock);
        #2 reset = 1'b1;
        qa_req = 1'b0;
        for (int i = 0; i < GH; i++) mdl_map[i] = '0;
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        repeat (4) @(posedge clock);
        do_query(1'b0, 12'd300, 12'd130, 3, 1'b0);
        do_query(1'b1, 12'd300, 12'd130, 3, 1'b0);

        // Randomised map and traffic against the model.
        for (int r = 0; r < GH; r++) load(r, 16'($urandom));
        for (int i = 0; i < 60; i++) begin
            logic [11:0] ax, ay, bx, by;
            int sel = $urandom_range(0, 3);
            ax = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 1150));
            ay = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 1150));
            bx = 12'($urandom_range(0, 1150));
            by = 12'($urandom_range(0, 1150));
            if (sel == 0) do_query(1'b0, ax, ay, 3, 1'b1);
            else if (sel == 1) do_query(1'b1, bx, by, 3, 1'b1);
            else if (sel == 2) begin
                fork
                    do_query(1'b0, ax, ay, -1, 1'b0);
                    do_query(1'b1, bx, by, -1, 1'b0);
                join
            end else load($urandom_range(0, GH - 1), 16'($urandom));
        end

        repeat (5) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
